// File: rtl/uart_16550_pkg.sv
// Shared types and constants for the 16550-style UART transmit path.
package uart_16550_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] WLEN_5 = 2'b00;
  localparam logic [1:0] WLEN_6 = 2'b01;
  localparam logic [1:0] WLEN_7 = 2'b10;
  localparam logic [1:0] WLEN_8 = 2'b11;

  localparam int OVERSAMPLE_DEF = 16;

  // Stop lengths in Baud_Tick_i pulses at the default oversample rate
  localparam int STOP_TICKS_1   = 16;
  localparam int STOP_TICKS_1P5 = 24;
  localparam int STOP_TICKS_2   = 32;

  function automatic logic [7:0] word_mask(input logic [1:0] wlen);
    logic [7:0] m;
    m = 8'hFF;
    case (wlen)
      WLEN_5:  m = 8'h1F;
      WLEN_6:  m = 8'h3F;
      WLEN_7:  m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uart_16550_tx_bit_timer.sv
// Counts Baud_Tick pulses and flags the tick that completes a bit of len_i ticks.
module uart_16550_tx_bit_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             bit_done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_done_o = tick_i && !clear_i && (cnt_q == len_i - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)         cnt_d = '0;
    else if (bit_done_o) cnt_d = '0;
    else if (tick_i)     cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_16550_tx_serializer.sv
// 16550-style transmit serializer: pops the Tx FIFO and shifts out start/data/parity/stop.
module uart_16550_tx_serializer
  import uart_16550_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       WBs_CLK_i,
  input  logic       WBs_RST_i,
  input  logic       Baud_Tick_i,
  input  logic [1:0] Word_Len_i,
  input  logic       Stop_Bits_i,
  input  logic       Parity_En_i,
  input  logic       Even_Parity_i,
  input  logic       Stick_Parity_i,
  input  logic       Break_Ctrl_i,
  input  logic       Tx_FIFO_Empty_i,
  input  logic [7:0] Tx_FIFO_DAT_i,
  output logic       Tx_FIFO_Pop_o,
  output logic       SOUT_o,
  output logic       Tx_Idle_o,
  output logic       Tx_Shift_Empty_o,
  output tx_state_e  Tx_State_o
);

  localparam int CNT_W  = $clog2(2 * OVERSAMPLE + 1);
  localparam int STOP_1   = STOP_TICKS_1   * OVERSAMPLE / OVERSAMPLE_DEF;
  localparam int STOP_1P5 = STOP_TICKS_1P5 * OVERSAMPLE / OVERSAMPLE_DEF;
  localparam int STOP_2   = STOP_TICKS_2   * OVERSAMPLE / OVERSAMPLE_DEF;

  tx_state_e  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] data_q, data_d;
  logic [1:0] wlen_q, wlen_d;
  logic       stop2_q, stop2_d, pen_q, pen_d, even_q, even_d, stick_q, stick_d;
  logic       sout_q, sout_d;
  logic       load, bit_done, fsm_bit, par_bit;
  logic [CNT_W-1:0] bit_len;

  // Pop handshake: Tx_FIFO_Pop_o is a one-cycle strobe, raised only while
  // Tx_FIFO_Empty_i=0; Tx_FIFO_DAT_i is captured on that same edge.
  assign Tx_FIFO_Pop_o    = load && !WBs_RST_i;
  assign SOUT_o           = sout_q;
  assign Tx_Idle_o        = (state_q == ST_IDLE);
  assign Tx_Shift_Empty_o = Tx_Idle_o && Tx_FIFO_Empty_i;
  assign Tx_State_o       = state_q;

  assign par_bit = stick_q ? ~even_q
                           : (even_q ? ^(data_q & word_mask(wlen_q))
                                     : ~^(data_q & word_mask(wlen_q)));

  always_comb begin
    bit_len = CNT_W'(OVERSAMPLE);
    if (state_q == ST_STOP) begin
      if (!stop2_q)              bit_len = CNT_W'(STOP_1);
      else if (wlen_q == WLEN_5) bit_len = CNT_W'(STOP_1P5);
      else                       bit_len = CNT_W'(STOP_2);
    end
  end

  uart_16550_tx_bit_timer #(.CNT_W(CNT_W)) u_bit_timer (
    .clk_i      (WBs_CLK_i),
    .rst_i      (WBs_RST_i),
    .clear_i    (state_q == ST_IDLE),
    .tick_i     (Baud_Tick_i),
    .len_i      (bit_len),
    .bit_done_o (bit_done)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    case (state_q)
      ST_IDLE:   if (!Tx_FIFO_Empty_i) load = 1'b1;
      ST_START:  if (bit_done) begin
                   state_d   = ST_DATA;
                   bit_cnt_d = 3'd0;
                 end
      ST_DATA:   if (bit_done) begin
                   if (bit_cnt_q == 3'd4 + {1'b0, wlen_q}) state_d = pen_q ? ST_PARITY : ST_STOP;
                   else bit_cnt_d = bit_cnt_q + 3'd1;
                 end
      ST_PARITY: if (bit_done) state_d = ST_STOP;
      ST_STOP:   if (bit_done) begin
                   if (!Tx_FIFO_Empty_i) load = 1'b1;
                   else state_d = ST_IDLE;
                 end
      default:   state_d = ST_IDLE;
    endcase

    data_d  = data_q;
    wlen_d  = wlen_q;
    stop2_d = stop2_q;
    pen_d   = pen_q;
    even_d  = even_q;
    stick_d = stick_q;
    if (load) begin
      state_d   = ST_START;
      bit_cnt_d = 3'd0;
      data_d    = Tx_FIFO_DAT_i;
      wlen_d    = Word_Len_i;
      stop2_d   = Stop_Bits_i;
      pen_d     = Parity_En_i;
      even_d    = Even_Parity_i;
      stick_d   = Stick_Parity_i;
    end

    // Line level follows the state being entered so SOUT_o is a clean register
    case (state_d)
      ST_START:  fsm_bit = 1'b0;
      ST_DATA:   fsm_bit = data_q[bit_cnt_d];
      ST_PARITY: fsm_bit = par_bit;
      default:   fsm_bit = 1'b1;
    endcase
    sout_d = Break_Ctrl_i ? 1'b0 : fsm_bit;
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      sout_q    <= 1'b1;
      data_q    <= 8'h00;
      wlen_q    <= 2'b00;
      stop2_q   <= 1'b0;
      pen_q     <= 1'b0;
      even_q    <= 1'b0;
      stick_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sout_q    <= sout_d;
      data_q    <= data_d;
      wlen_q    <= wlen_d;
      stop2_q   <= stop2_d;
      pen_q     <= pen_d;
      even_q    <= even_d;
      stick_q   <= stick_d;
    end
  end

endmodule

// File: tb/tb_uart_16550_tx_serializer.sv
// Directed bench: frames are captured one sample per baud tick and compared to hand-built bit patterns.
module tb_uart_16550_tx_serializer;
  import uart_16550_pkg::*;

  localparam int TICK_DIV = 3;
  localparam int BUDGET   = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic [1:0] word_len = 2'b11;
  logic       stop_bits = 1'b0, par_en = 1'b0, even_par = 1'b0, stick_par = 1'b0;
  logic       brk = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dat = 8'h00;
  logic       pop_o, sout_o, idle_o, temt_o;
  tx_state_e  state_o;

  logic [7:0] fifo_q[$];
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  int n_vec = 0, n_err = 0, cyc = 0;
  logic s_pop, s_sout, s_idle, s_temt, s_tick;

  always #5 clk = ~clk;

  uart_16550_tx_serializer dut (
    .WBs_CLK_i        (clk),
    .WBs_RST_i        (rst),
    .Baud_Tick_i      (baud_tick),
    .Word_Len_i       (word_len),
    .Stop_Bits_i      (stop_bits),
    .Parity_En_i      (par_en),
    .Even_Parity_i    (even_par),
    .Stick_Parity_i   (stick_par),
    .Break_Ctrl_i     (brk),
    .Tx_FIFO_Empty_i  (fifo_empty),
    .Tx_FIFO_DAT_i    (fifo_dat),
    .Tx_FIFO_Pop_o    (pop_o),
    .SOUT_o           (sout_o),
    .Tx_Idle_o        (idle_o),
    .Tx_Shift_Empty_o (temt_o),
    .Tx_State_o       (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fifo_refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dat   = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] d);
    fifo_q.push_back(d);
    fifo_refresh();
  endtask

  // Sample outputs at negedge, then advance one clock; FIFO pops and ticks update #1 after the edge
  task automatic step();
    @(negedge clk);
    s_pop = pop_o; s_sout = sout_o; s_idle = idle_o; s_temt = temt_o; s_tick = baud_tick;
    @(posedge clk);
    #1;
    if (s_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_refresh();
    cyc++;
    baud_tick = (cyc % TICK_DIV == 0);
  endtask

  task automatic set_cfg(input logic [1:0] wl, input logic sb, input logic pe, input logic ev, input logic st);
    word_len = wl; stop_bits = sb; par_en = pe; even_par = ev; stick_par = st;
  endtask

  // bits[0] is sent first; the last bit is the stop bit and lasts stop_ticks
  task automatic add_frame(input logic [11:0] bits, input int nbits, input int stop_ticks);
    for (int i = 0; i < nbits; i++) begin
      int reps;
      reps = (i == nbits - 1) ? stop_ticks : 16;
      for (int r = 0; r < reps; r++) exp_q.push_back(bits[i]);
    end
  endtask

  task automatic capture(input bit scramble, input int brk_on, input int brk_off, output int n_pops);
    bit started, done;
    int n_ticks;
    started = 0; done = 0; n_ticks = 0; n_pops = 0;
    got_q.delete();
    for (int c = 0; c < BUDGET && !done; c++) begin
      step();
      if (s_pop) n_pops++;
      if (started && s_idle) done = 1;
      else if (!started && s_pop) started = 1;
      else if (started && s_tick) begin
        got_q.push_back(s_sout);
        n_ticks++;
        if (n_ticks == brk_on)  brk = 1'b1;
        if (n_ticks == brk_off) brk = 1'b0;
        if (scramble && n_ticks == 5)
          set_cfg(~word_len, ~stop_bits, ~par_en, ~even_par, ~stick_par);
      end
    end
    if (!done) check("capture_timeout", 32'(done), 32'd1);
  endtask

  task automatic compare_frame(input string tag, input int pops, input int exp_pops);
    int bad, n;
    check({tag, "_ticks"}, 32'(got_q.size()), 32'(exp_q.size()));
    bad = 0;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) bad++;
    check({tag, "_bad_ticks"}, 32'(bad), 32'd0);
    check({tag, "_pops"}, 32'(pops), 32'(exp_pops));
    check({tag, "_temt"}, 32'(s_temt), 32'd1);
    exp_q.delete();
  endtask

  initial begin
    int pops, ticks;
    bit seen;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("rst_sout", 32'(sout_o), 32'd1);
    check("rst_idle", 32'(idle_o), 32'd1);
    check("rst_pop", 32'(pop_o), 32'd0);
    check("rst_temt", 32'(temt_o), 32'd1);
    check("rst_state", 32'(state_o), 32'(ST_IDLE));
    repeat (5) step();
    check("idle_no_pop", 32'(s_pop), 32'd0);

    // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1,1
    set_cfg(WLEN_8, 1'b0, 1'b0, 1'b0, 1'b0);
    push(8'hA5);
    add_frame(12'h34A, 10, 16);
    capture(0, 0, 0, pops);
    compare_frame("f8n1_a5", pops, 1);

    // 7E1, 0x41: 0,1000001,0,1 -- config scrambled mid-frame
    set_cfg(WLEN_7, 1'b0, 1'b1, 1'b1, 1'b0);
    push(8'h41);
    add_frame(12'h282, 10, 16);
    capture(1, 0, 0, pops);
    compare_frame("f7e1_41", pops, 1);

    // 5O1.5, 0x1F: 0,11111,0 then stop for 24 ticks
    set_cfg(WLEN_5, 1'b1, 1'b1, 1'b0, 1'b0);
    push(8'h1F);
    add_frame(12'h0BE, 8, 24);
    capture(1, 0, 0, pops);
    compare_frame("f5o15_1f", pops, 1);

    // Stick parity, 6 bits, 0x2A, Even=1 -> parity bit 0; 2 stop bits (32 ticks)
    set_cfg(WLEN_6, 1'b1, 1'b1, 1'b1, 1'b1);
    push(8'h2A);
    add_frame(12'h354, 9, 32);
    capture(0, 0, 0, pops);
    compare_frame("f6s2_2a", pops, 1);

    // Three back-to-back 8N1 frames: 0x11, 0x22, 0x33
    set_cfg(WLEN_8, 1'b0, 1'b0, 1'b0, 1'b0);
    push(8'h11); push(8'h22); push(8'h33);
    add_frame(12'h222, 10, 16);
    add_frame(12'h244, 10, 16);
    add_frame(12'h266, 10, 16);
    capture(0, 0, 0, pops);
    compare_frame("b2b", pops, 3);

    // Break held for 100 ticks mid-frame on 0xFF
    push(8'hFF);
    add_frame(12'h3FE, 10, 16);
    for (int i = 21; i <= 120; i++) exp_q[i] = 1'b0;
    capture(0, 21, 121, pops);
    compare_frame("break", pops, 1);

    // Reset during DATA bit 3 of 0xA5; 0x3C must then go out as a fresh frame
    push(8'hA5); push(8'h3C);
    seen = 0; ticks = 0; pops = 0;
    for (int c = 0; c < BUDGET && ticks < 70; c++) begin
      step();
      if (s_pop) begin pops++; seen = 1; end
      else if (seen && s_tick) ticks++;
    end
    check("rst_mid_ticks", 32'(ticks), 32'd70);
    check("rst_mid_state", 32'(state_o), 32'(ST_DATA));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_sout", 32'(sout_o), 32'd1);
    check("rst_mid_idle", 32'(state_o), 32'(ST_IDLE));
    check("rst_mid_pops", 32'(pops), 32'd1);
    add_frame(12'h278, 10, 16);
    capture(0, 0, 0, pops);
    compare_frame("after_rst_3c", pops, 1);
    check("fifo_drained", 32'(fifo_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
